// File: rtl/draw_pkg.sv
// Shared glyph codes, controller state encoding and default text spacing for the
// text drawing controller.
package draw_pkg;

  localparam int unsigned GlyphA       = 15;
  localparam int unsigned GlyphE       = 17;
  localparam int unsigned GlyphF       = 18;
  localparam int unsigned GlyphI       = 20;
  localparam int unsigned GlyphL       = 21;
  localparam int unsigned GlyphV       = 28;
  localparam int unsigned GlyphD       = 30;
  localparam int unsigned GlyphSpace   = 31;
  localparam int unsigned GlyphNewline = 29;

  localparam int unsigned DefaultCharAdv = 12;
  localparam int unsigned DefaultLineAdv = 24;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDraw,
    StDone
  } state_e;

endpackage

// File: rtl/text_buffer.sv
// Character buffer: DEPTH x WIDTH register file, one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module text_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 5
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/draw_text_control.sv
// Glyph sequencer: walks a loaded character buffer and issues one drawer request per
// printable glyph, handling space, newline, right-margin wrap and abort.
module draw_text_control
  import draw_pkg::*;
#(
  parameter int unsigned MAX_CHARS    = 16,
  parameter int unsigned TYPE_W       = 5,
  parameter int unsigned X_W          = 9,
  parameter int unsigned Y_W          = 8,
  parameter int unsigned CHAR_ADV     = DefaultCharAdv,
  parameter int unsigned LINE_ADV     = DefaultLineAdv,
  parameter int unsigned X_MARGIN     = 300,
  parameter int unsigned SPACE_CODE   = GlyphSpace,
  parameter int unsigned NEWLINE_CODE = GlyphNewline
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic                           wr_en_i,
  input  logic [$clog2(MAX_CHARS)-1:0]   wr_addr_i,
  input  logic [TYPE_W-1:0]              wr_code_i,
  input  logic [$clog2(MAX_CHARS+1)-1:0] len_i,
  input  logic [X_W-1:0]                 x_origin_i,
  input  logic [Y_W-1:0]                 y_origin_i,
  input  logic                           draw_object_done_i,
  output logic                           start_draw_o,
  output logic [TYPE_W-1:0]              obj_type_o,
  output logic [X_W-1:0]                 x_out_o,
  output logic [Y_W-1:0]                 y_out_o,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int unsigned AW = $clog2(MAX_CHARS);
  localparam int unsigned LW = $clog2(MAX_CHARS + 1);

  localparam logic [X_W-1:0]    XAdv    = X_W'(CHAR_ADV);
  localparam logic [Y_W-1:0]    YAdv    = Y_W'(LINE_ADV);
  localparam logic [X_W:0]      Margin  = (X_W + 1)'(X_MARGIN);
  localparam logic [LW-1:0]     MaxLen  = LW'(MAX_CHARS);
  localparam logic [TYPE_W-1:0] SpCode  = TYPE_W'(SPACE_CODE);
  localparam logic [TYPE_W-1:0] NlCode  = TYPE_W'(NEWLINE_CODE);

  state_e             state_q, state_d;
  logic [LW-1:0]      idx_q, idx_d;
  logic [LW-1:0]      len_q, len_d;
  logic [X_W-1:0]     x_cur_q, x_cur_d;
  logic [X_W-1:0]     x_org_q, x_org_d;
  logic [Y_W-1:0]     y_cur_q, y_cur_d;
  logic               start_draw_q, start_draw_d;
  logic [TYPE_W-1:0]  obj_type_q, obj_type_d;
  logic [X_W-1:0]     x_out_q, x_out_d;
  logic [Y_W-1:0]     y_out_q, y_out_d;

  logic [TYPE_W-1:0]  rd_code;
  logic [X_W:0]       x_next_ext;
  logic               wrap;
  logic               wr_ok;

  assign wr_ok = wr_en_i && (state_q == StIdle);

  text_buffer #(
    .DEPTH (MAX_CHARS),
    .WIDTH (TYPE_W)
  ) u_text_buffer (
    .clk_i   (clk_i),
    .we_i    (wr_ok),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_code_i),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (rd_code)
  );

  // One extra bit so a glyph near the top of the x range cannot alias below the margin.
  assign x_next_ext = {1'b0, x_cur_q} + {1'b0, XAdv};
  assign wrap       = x_next_ext > Margin;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    len_d        = len_q;
    x_cur_d      = x_cur_q;
    x_org_d      = x_org_q;
    y_cur_d      = y_cur_q;
    start_draw_d = start_draw_q;
    obj_type_d   = obj_type_q;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          len_d   = (len_i > MaxLen) ? MaxLen : len_i;
          x_org_d = x_origin_i;
          x_cur_d = x_origin_i;
          y_cur_d = y_origin_i;
          idx_d   = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (idx_q == len_q) begin
          state_d = StDone;
        end else if (rd_code == NlCode) begin
          x_cur_d = x_org_q;
          y_cur_d = y_cur_q + YAdv;
          idx_d   = idx_q + LW'(1);
        end else if (rd_code == SpCode) begin
          x_cur_d = x_cur_q + XAdv;
          idx_d   = idx_q + LW'(1);
        end else begin
          if (wrap) begin
            x_cur_d = x_org_q;
            y_cur_d = y_cur_q + YAdv;
          end
          // Outputs carry the post-wrap position so they are valid in the first DRAW cycle.
          start_draw_d = 1'b1;
          obj_type_d   = rd_code;
          x_out_d      = x_cur_d;
          y_out_d      = y_cur_d;
          state_d      = StDraw;
        end
      end
      StDraw: begin
        if (draw_object_done_i) begin
          x_cur_d      = x_cur_q + XAdv;
          idx_d        = idx_q + LW'(1);
          start_draw_d = 1'b0;
          obj_type_d   = '0;
          x_out_d      = '0;
          y_out_d      = '0;
          state_d      = StFetch;
        end
      end
      StDone: begin
        if (!start_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort_i && (state_q != StIdle)) begin
      state_d      = StIdle;
      start_draw_d = 1'b0;
      obj_type_d   = '0;
      x_out_d      = '0;
      y_out_d      = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      len_q        <= '0;
      x_cur_q      <= '0;
      x_org_q      <= '0;
      y_cur_q      <= '0;
      start_draw_q <= 1'b0;
      obj_type_q   <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      len_q        <= len_d;
      x_cur_q      <= x_cur_d;
      x_org_q      <= x_org_d;
      y_cur_q      <= y_cur_d;
      start_draw_q <= start_draw_d;
      obj_type_q   <= obj_type_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
    end
  end

  assign start_draw_o = start_draw_q;
  assign obj_type_o   = obj_type_q;
  assign x_out_o      = x_out_q;
  assign y_out_o      = y_out_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);

endmodule
